// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N valid/ready packet demultiplexer with a per-channel slot.
// Optional per-channel handshake counters: define DEMUX_STREAM_BEAT_COUNT_EN.
module demux_1ton_stream #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_last,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               err_sel
`ifdef DEMUX_STREAM_BEAT_COUNT_EN
  ,
  output logic [N*16-1:0]    beat_count
`endif
);

  localparam int NP = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    DROP
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] target;
  logic [NP-1:0]    slot_free;
  logic [N-1:0]     load;
  logic             sel_bad;
  logic             drop_beat;
  logic             accept;

  // Padded to a power of two so an out-of-range select indexes safely
  always_comb begin
    slot_free        = '0;
    slot_free[N-1:0] = ~out_valid | out_ready;
  end

  assign target    = (state == PKT) ? sel_q : in_sel;
  assign sel_bad   = (state == IDLE) && (32'(in_sel) >= N);
  assign drop_beat = (state == DROP) || sel_bad;
  assign in_ready  = drop_beat || slot_free[target];
  assign accept    = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && !drop_beat &&
                (target == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_last  <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          out_valid[k]              <= 1'b1;
          out_last[k]               <= in_last;
          out_data[k*WIDTH +: WIDTH] <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      err_sel <= 1'b0;
    end else begin
      err_sel <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (sel_bad) begin
              err_sel <= 1'b1;
              if (!in_last) state <= DROP;
            end else if (!in_last) begin
              sel_q <= in_sel;
              state <= PKT;
            end
          end
        end
        PKT, DROP: begin
          if (accept && in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_STREAM_BEAT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          beat_count[k*16 +: 16] <= beat_count[k*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream: N=4 main instance, N=3 for bad selects.
// Counter checks run only when DEMUX_STREAM_BEAT_COUNT_EN is defined.
module tb_demux_1ton_stream;

  int total = 0;
  int bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;

  logic        rst1;
  logic [7:0]  d1;
  logic [1:0]  s1;
  logic        l1;
  logic        v1;
  logic        r1;
  logic [23:0] od1;
  logic [2:0]  ol1;
  logic [2:0]  ov1;
  logic [2:0]  or1;
  logic        e1;

`ifdef DEMUX_STREAM_BEAT_COUNT_EN
  logic [63:0] beat_count;
  logic [47:0] bc1;
`endif

  demux_1ton_stream #(.WIDTH(8), .N(4)) u0 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_sel(err_sel)
`ifdef DEMUX_STREAM_BEAT_COUNT_EN
    , .beat_count(beat_count)
`endif
  );

  demux_1ton_stream #(.WIDTH(8), .N(3)) u1 (
    .clk(clk), .rst(rst1),
    .in_data(d1), .in_sel(s1), .in_last(l1),
    .in_valid(v1), .in_ready(r1),
    .out_data(od1), .out_last(ol1),
    .out_valid(ov1), .out_ready(or1),
    .err_sel(e1)
`ifdef DEMUX_STREAM_BEAT_COUNT_EN
    , .beat_count(bc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_data;

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    in_data = '0; in_sel = '0; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 4'hF;
    d1 = '0; s1 = '0; l1 = 1'b0; v1 = 1'b0; or1 = 3'h7;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_err", 32'(err_sel), 0);
    chk("rst1_valid", 32'(ov1), 0);
    rst = 1'b0; rst1 = 1'b0;
    tick();

    // reset in the middle of a 3-beat packet to ch2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h31; in_last = 1'b0;
    tick();
    chk("mid_b1_valid", 32'(out_valid), 32'h4);
    in_data = 8'h32;
    tick();
    chk("mid_b2_data", 32'(out_data[23:16]), 32'h32);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", out_data, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h41; in_last = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'h2);
    chk("post_rst_data", 32'(out_data[15:8]), 32'h41);
    in_valid = 1'b0;
    tick();
    chk("post_rst_drain", 32'(out_valid), 0);

    // routing sweep, back-to-back 1-beat packets
    exp_data = 32'h0000_4100;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k);
      in_data = 8'hA0 + 8'(k); in_last = 1'b1;
      tick();
      exp_data[k*8 +: 8] = 8'hA0 + 8'(k);
      chk("sweep_valid", 32'(out_valid), 32'(1 << k));
      chk("sweep_data", out_data, exp_data);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_idle", 32'(out_valid), 0);

    // select locked on header beat
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel = (i == 0) ? 2'd3 : 2'd0;
      in_data = 8'h11 + 8'(i);
      in_last = (i == 3);
      tick();
      chk("lock_valid", 32'(out_valid), 32'h8);
      chk("lock_data", 32'(out_data[31:24]), 32'h11 + 32'(i));
      chk("lock_last", 32'(out_last & out_valid), (i == 3) ? 32'h8 : 32'h0);
    end
    in_valid = 1'b0;
    tick();
    chk("lock_ch0_data", 32'(out_data[7:0]), 32'hA0);
    chk("lock_idle", 32'(out_valid), 0);

    // backpressure on ch1
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h51; in_last = 1'b0;
    #1;
    chk("bp_rdy_first", 32'(in_ready), 1);
    tick();
    chk("bp_b1_valid", 32'(out_valid), 32'h2);
    chk("bp_b1_data", 32'(out_data[15:8]), 32'h51);
    in_data = 8'h52; in_sel = 2'd3;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_rdy", 32'(in_ready), 0);
      chk("bp_hold_data", 32'(out_data[15:8]), 32'h51);
      chk("bp_hold_valid", 32'(out_valid), 32'h2);
      tick();
    end
    out_ready = 4'hF;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 1);
    tick();
    chk("bp_b2_data", 32'(out_data[15:8]), 32'h52);
    chk("bp_b2_valid", 32'(out_valid), 32'h2);
    chk("bp_b2_last", 32'(out_last[1]), 0);
    in_data = 8'h53; in_last = 1'b1;
    tick();
    chk("bp_b3_data", 32'(out_data[15:8]), 32'h53);
    chk("bp_b3_last", 32'(out_last[1]), 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("bp_idle", 32'(out_valid), 0);

    // invalid select on the N=3 instance
    v1 = 1'b1; s1 = 2'd3; d1 = 8'h61; l1 = 1'b0;
    #1;
    chk("inv_rdy_hdr", 32'(r1), 1);
    tick();
    chk("inv_err_pulse", 32'(e1), 1);
    chk("inv_no_valid", 32'(ov1), 0);
    s1 = 2'd0; d1 = 8'h62; l1 = 1'b1;
    #1;
    chk("inv_rdy_drop", 32'(r1), 1);
    tick();
    chk("inv_err_single", 32'(e1), 0);
    chk("inv_no_valid2", 32'(ov1), 0);
    d1 = 8'h63; s1 = 2'd0; l1 = 1'b1;
    tick();
    chk("inv_next_valid", 32'(ov1), 32'h1);
    chk("inv_next_data", 32'(od1[7:0]), 32'h63);
    chk("inv_next_err", 32'(e1), 0);
    v1 = 1'b0;
    tick();
    chk("inv_idle", 32'(ov1), 0);

`ifdef DEMUX_STREAM_BEAT_COUNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("bc_rst_lo", beat_count[31:0], 0);
    chk("bc_rst_hi", beat_count[63:32], 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = 2'd2;
      in_data = 8'(i); in_last = (i == 4);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("bc_ch2", 32'(beat_count[47:32]), 5);
    chk("bc_ch0", 32'(beat_count[15:0]), 0);
    chk("bc_ch1", 32'(beat_count[31:16]), 0);
    chk("bc_ch3", 32'(beat_count[63:48]), 0);
    in_valid = 1'b1; in_sel = 2'd0; in_last = 1'b1;
    repeat (65535) tick();
    in_valid = 1'b0;
    tick();
    chk("bc_ch0_max", 32'(beat_count[15:0]), 32'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bc_ch0_wrap", 32'(beat_count[15:0]), 0);
    chk("bc_ch2_keep", 32'(beat_count[47:32]), 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
